// File: rtl/ddr_pkg.sv
// Shared types and sizing helpers for the DDR receive deserializer.
// A word is built from 2-bit pairs, one pair per clock cycle.
package ddr_pkg;

  localparam int DDR_PAIR_W = 2;

  typedef logic [DDR_PAIR_W-1:0] pair_t;

  // What the output register does at a given posedge
  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_LOAD,
    OUT_DROP,
    OUT_FREE
  } out_act_t;

  function automatic int pairs_per_word(input int width);
    return width / DDR_PAIR_W;
  endfunction

  // Pair counter width; a one-pair word still gets a 1-bit counter
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / DDR_PAIR_W);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DDR_DEF_WIDTH = 8;
  localparam int DDR_DEF_CNT_W = cnt_width(DDR_DEF_WIDTH);

endpackage

// File: rtl/ddr_deser_if.sv
// Parallel word output stream of the deserializer (valid/ready).
interface ddr_deser_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/ddr_pair_capture.sv
// Dual-edge front end: holds the only negedge flop of the deserializer so
// timing constraints can target this single instance.
module ddr_pair_capture
  import ddr_pkg::*;
(
  input  logic  clk,
  input  logic  sdi,
  output pair_t pair
);

  logic neg_bit;

  // Even bit: no reset, consumers ignore it unless qualified by sdi_vld
  always_ff @(negedge clk) begin
    neg_bit <= sdi;
  end

  // Odd bit is sdi itself; it is registered by the posedge consumer
  assign pair = {sdi, neg_bit};

endmodule

// File: rtl/ddr_deser.sv
// DDR input deserializer: assembles 2-bit-per-cycle pairs LSB first into
// WIDTH-bit words and presents them on a registered valid/ready port.
module ddr_deser
  import ddr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sdi,
  input  logic           sdi_vld,
  input  logic           sdi_sof,
  ddr_deser_if.master    m,
  output logic           ovf,
  output logic           align_err
);

  localparam int                PAIRS = pairs_per_word(WIDTH);
  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PAIRS - 1);

  pair_t            pair;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             done;
  logic             misalign;
  out_act_t         act;

  ddr_pair_capture u_cap (
    .clk  (clk),
    .sdi  (sdi),
    .pair (pair)
  );

  // A start-of-frame pair always lands in slot 0, discarding any partial word
  always_comb begin
    pos      = sdi_sof ? '0 : cnt;
    acc_nxt  = sdi_sof ? '0 : acc;
    for (int i = 0; i < PAIRS; i++) begin
      if (pos == CNT_W'(i)) acc_nxt[DDR_PAIR_W*i +: DDR_PAIR_W] = pair;
    end
    cnt_nxt  = (pos == LAST) ? '0 : pos + 1'b1;
    done     = sdi_vld && (pos == LAST);
    misalign = sdi_vld && sdi_sof && (cnt != '0);

    act = OUT_IDLE;
    if (done) begin
      act = (!m.m_valid || m.m_ready) ? OUT_LOAD : OUT_DROP;
    end else if (m.m_valid && m.m_ready) begin
      act = OUT_FREE;
    end
  end

  // ---- posedge stage: accumulate pair, update output register and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      m.m_data  <= '0;
      m.m_valid <= 1'b0;
      ovf       <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (sdi_vld) begin
        cnt <= cnt_nxt;
        acc <= acc_nxt;
      end
      if (misalign) align_err <= 1'b1;
      case (act)
        OUT_LOAD: begin
          m.m_data  <= acc_nxt;
          m.m_valid <= 1'b1;
        end
        OUT_DROP: ovf       <= 1'b1;
        OUT_FREE: m.m_valid <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_deser.sv
// Bench for ddr_deser: directed steps then random traffic, with WIDTH=8 and
// WIDTH=2 instances sharing the serial inputs, against a bit-queue model.
module tb_ddr_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sdi = 1'b0;
  logic sdi_vld = 1'b0;
  logic sdi_sof = 1'b0;
  logic m_ready = 1'b0;
  logic ovf8, aerr8, ovf2, aerr2;

  int tests = 0;
  int fails = 0;

  ddr_deser_if #(.WIDTH(8)) bus8 ();
  ddr_deser_if #(.WIDTH(2)) bus2 ();

  assign bus8.m_ready = m_ready;
  assign bus2.m_ready = m_ready;

  ddr_deser #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_vld(sdi_vld), .sdi_sof(sdi_sof),
    .m(bus8), .ovf(ovf8), .align_err(aerr8)
  );

  ddr_deser #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_vld(sdi_vld), .sdi_sof(sdi_sof),
    .m(bus2), .ovf(ovf2), .align_err(aerr2)
  );

  always #5 clk = ~clk;

  // Reference state: received bits of the current word, in arrival order
  bit         bq[$];
  logic [7:0] e_data = '0;
  bit         e_valid = 0, e_ovf = 0, e_aerr = 0;
  logic [1:0] e2_data = '0;
  bit         e2_valid = 0, e2_ovf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit n, input bit p, input bit v,
                            input bit s, input bit rd);
    bit         done;
    logic [7:0] w;
    done = 0;
    w    = '0;
    if (r) begin
      bq.delete();
      e_data = '0; e_valid = 0; e_ovf = 0; e_aerr = 0;
      e2_data = '0; e2_valid = 0; e2_ovf = 0;
    end else begin
      if (v) begin
        if (s) begin
          if (bq.size() != 0) e_aerr = 1;
          bq.delete();
        end
        bq.push_back(n);
        bq.push_back(p);
        if (bq.size() == 8) begin
          for (int i = 0; i < 8; i++) w[i] = bq[i];
          bq.delete();
          done = 1;
        end
      end
      if (done) begin
        if (!e_valid || rd) begin e_data = w; e_valid = 1; end
        else e_ovf = 1;
      end else if (e_valid && rd) e_valid = 0;

      if (v) begin
        if (!e2_valid || rd) begin e2_data = {p, n}; e2_valid = 1; end
        else e2_ovf = 1;
      end else if (e2_valid && rd) e2_valid = 0;
    end
  endtask

  // One clock: even bit before negedge, odd bit and controls at posedge
  task automatic cycle(input bit r, input bit n, input bit p, input bit v,
                       input bit s, input bit rd);
    rst = r; sdi = n; sdi_vld = v; sdi_sof = s; m_ready = rd;
    @(negedge clk);
    #1 sdi = p;
    model_edge(r, n, p, v, s, rd);
    @(posedge clk);
    #1;
    check("w8_valid", 32'(bus8.m_valid), 32'(e_valid));
    check("w8_data",  32'(bus8.m_data),  32'(e_data));
    check("w8_ovf",   32'(ovf8),         32'(e_ovf));
    check("w8_aerr",  32'(aerr8),        32'(e_aerr));
    check("w2_valid", 32'(bus2.m_valid), 32'(e2_valid));
    check("w2_data",  32'(bus2.m_data),  32'(e2_data));
    check("w2_ovf",   32'(ovf2),         32'(e2_ovf));
    check("w2_aerr",  32'(aerr2),        32'(0));
  endtask

  task automatic idle(input bit rd);
    cycle(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0,
          bit'($urandom_range(0, 1)), rd);
  endtask

  task automatic send_word(input logic [7:0] w, input bit sof, input bit rd_mid,
                           input bit rd_last, input int gap);
    for (int k = 0; k < 4; k++) begin
      cycle(0, w[2*k], w[2*k+1], 1, sof && (k == 0), (k == 3) ? rd_last : rd_mid);
      if (k == 1) for (int g = 0; g < gap; g++) idle(rd_mid);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_valid", 32'(bus8.m_valid), 32'(0));
    check("reset_data",  32'(bus8.m_data),  32'(0));

    send_word(8'hA5, 1, 1, 1, 0);
    check("a5_data",  32'(bus8.m_data),  32'h000000A5);
    check("a5_valid", 32'(bus8.m_valid), 32'(1));
    idle(1);
    check("a5_one_cycle", 32'(bus8.m_valid), 32'(0));

    send_word(8'h3C, 1, 1, 1, 5);
    check("3c_data", 32'(bus8.m_data), 32'h0000003C);
    idle(1);

    send_word(8'h11, 1, 0, 0, 0);
    send_word(8'h22, 1, 0, 0, 0);
    check("hold_data", 32'(bus8.m_data), 32'h00000011);
    check("ovf_set",   32'(ovf8),        32'(1));
    idle(1);
    check("drain_valid", 32'(bus8.m_valid), 32'(0));

    cycle(1, 0, 0, 0, 0, 0);
    send_word(8'hAA, 1, 1, 1, 0);
    send_word(8'h55, 1, 0, 1, 0);
    check("b2b_data",  32'(bus8.m_data),  32'h00000055);
    check("b2b_valid", 32'(bus8.m_valid), 32'(1));
    check("b2b_ovf",   32'(ovf8),         32'(0));
    idle(1);

    cycle(0, 1, 1, 1, 1, 1);
    cycle(0, 0, 1, 1, 0, 1);
    send_word(8'hF0, 1, 1, 1, 0);
    check("aerr_set",  32'(aerr8),        32'(1));
    check("aerr_data", 32'(bus8.m_data),  32'h000000F0);
    idle(1);

    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 1, 1, 1);
    cycle(0, 1, 1, 1, 0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    send_word(8'h99, 1, 1, 1, 0);
    check("rst_mid_data", 32'(bus8.m_data), 32'h00000099);
    check("rst_mid_ovf",  32'(ovf8),        32'(0));
    check("rst_mid_aerr", 32'(aerr8),       32'(0));

    for (int c = 0; c < 600; c++) begin
      cycle(bit'($urandom_range(0, 59) == 0),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
